// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared constants and state encoding for the instruction
//               fetch stage (state codes, NOP word, PC step, memory size,
//               and the word-in-range helper).
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int unsigned IF_MEM_SIZE = 128;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

    // Fetch FSM state encoding
    typedef logic [0:0] if_state_t;
    localparam if_state_t c_ST_RUN  = 1'b0;
    localparam if_state_t c_ST_HALT = 1'b1;

    // A 4-byte word at addr fits if its last byte is inside memory.
    // addr + 3 wraps modulo 2^32 on purpose.
    function automatic logic if_word_in_range(input logic [31:0] addr,
                                              input int unsigned mem_size);
        logic [31:0] w_last_byte;
        logic [31:0] w_mem_last;
        w_last_byte = addr + 32'd3;
        w_mem_last  = 32'(mem_size - 1);
        return (w_last_byte <= w_mem_last);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Bubble (or reset) clears it to a
//               NOP with valid low; load captures a fetched word and its
//               address; otherwise contents are held.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);
    import if_pkg::*;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // Bubble outranks load; neither asserted means hold
    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'h0;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + PC_STEP;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the PC, addresses the
//               instruction memory, fills the IF/ID register, and handles
//               stall, flush, branch redirect and end-of-memory halt.
//               Optional macro IF_ALIGN_CHECK_EN adds a sticky Fault output
//               for misaligned redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int unsigned MEM_SIZE = 128,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] InstrAddr,
    input  logic [31:0] Instr,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPC,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        Halted
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        Fault
`endif
);
    import if_pkg::*;

    if_state_t   r_state;
    if_state_t   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_fault;
    logic        w_fault_set;
    logic        w_load;
    logic        w_bubble;
    logic        w_pc_in_range;
    logic        w_tgt_in_range;
    logic        w_misalign;
    logic [31:0] w_target;

    // Low two target bits are dropped; with the check enabled a misaligned
    // target never reaches the PC anyway.
    assign w_target       = BranchTarget & ~32'h3;
    assign w_pc_in_range  = if_word_in_range(r_pc, MEM_SIZE);
    assign w_tgt_in_range = if_word_in_range(w_target, MEM_SIZE);

`ifdef IF_ALIGN_CHECK_EN
    assign w_misalign = BranchTaken && (BranchTarget[1:0] != 2'b00);
    assign Fault      = r_fault;
`else
    assign w_misalign = 1'b0;
`endif

    // Next-state, next-PC and IF/ID control decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                if (w_pc_in_range) begin
                    if (Flush) begin
                        w_bubble = 1'b1;
                    end else if (!Stall) begin
                        w_load = 1'b1;
                    end
                    if (w_misalign) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = c_ST_HALT;
                    end else if (BranchTaken) begin
                        w_pc_nxt = w_target;
                    end else if (!Stall) begin
                        w_pc_nxt = r_pc + PC_STEP;
                    end
                end else begin
                    // Nothing to fetch: feed bubbles and halt unless rescued
                    w_bubble = Flush || !Stall;
                    if (w_misalign) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = c_ST_HALT;
                    end else if (BranchTaken && w_tgt_in_range) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_state_nxt = c_ST_HALT;
                    end
                end
            end
            c_ST_HALT: begin
                w_bubble = Flush || !Stall;
                if (w_misalign) begin
                    w_fault_set = 1'b1;
                end else if (BranchTaken && w_tgt_in_range && !r_fault) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    // State, PC and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= r_fault | w_fault_set;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_instr    (Instr),
        .i_pc       (r_pc),
        .o_instr    (IfIdInstr),
        .o_pc       (IfIdPC),
        .o_pc_plus4 (IfIdPCPlus4),
        .o_valid    (IfIdValid)
    );

    assign InstrAddr = r_pc;
    assign Halted    = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch. Stimulus queues the
//               expected post-edge state; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InstrAddr;
    logic [31:0] Instr;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPC;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;
    logic        Halted;
    logic        fault_obs;

    always #5 clk = ~clk;

`ifdef IF_ALIGN_CHECK_EN
    logic Fault;
    assign fault_obs = Fault;
`else
    assign fault_obs = 1'b0;
`endif

    instr_fetch #(.MEM_SIZE(128), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .Stall        (Stall),
        .Flush        (Flush),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InstrAddr    (InstrAddr),
        .Instr        (Instr),
        .IfIdInstr    (IfIdInstr),
        .IfIdPC       (IfIdPC),
        .IfIdPCPlus4  (IfIdPCPlus4),
        .IfIdValid    (IfIdValid),
        .Halted       (Halted)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .Fault        (Fault)
`endif
    );

    // Instruction memory contents (word view of the 128-byte IM)
    function automatic logic [31:0] imw(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0001;
        if (a == 32'h4) return 32'h2009_0002;
        return 32'h3C00_0000 | a;
    endfunction

    // Out-of-range reads return junk that must never be captured
    assign Instr = ((InstrAddr + 32'd3) <= 32'd127) ? imw(InstrAddr) : 32'hDEAD_BEEF;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        fault;
        bit          chk_pc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string name, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] pc, input logic [31:0] pc4, input logic valid,
                        input logic halted, input logic fault, input bit chk_pc);
        exp_t e;
        e.cyc = cyc + 1;
        e.name = name;
        e.addr = addr;
        e.instr = instr;
        e.pc = pc;
        e.pc4 = pc4;
        e.valid = valid;
        e.halted = halted;
        e.fault = fault;
        e.chk_pc = chk_pc;
        sbq.push_back(e);
    endtask

    // Expect a normal fetch of the word at pc, PC advancing to next_addr
    task automatic push_fetch(input string name, input logic [31:0] pc, input logic [31:0] next_addr);
        push(name, next_addr, imw(pc), pc, pc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every due expectation on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                exp_t e;
                bit   ok;
                e = sbq.pop_front();
                ok = (InstrAddr === e.addr) && (IfIdInstr === e.instr) &&
                     (IfIdValid === e.valid) && (Halted === e.halted);
                if (e.chk_pc) ok = ok && (IfIdPC === e.pc) && (IfIdPCPlus4 === e.pc4);
`ifdef IF_ALIGN_CHECK_EN
                ok = ok && (Fault === e.fault);
`endif
                n_vec++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s: got addr=%h instr=%h pc=%h pc4=%h v=%b h=%b f=%b; want addr=%h instr=%h pc=%h pc4=%h v=%b h=%b f=%b",
                             e.name, InstrAddr, IfIdInstr, IfIdPC, IfIdPCPlus4, IfIdValid, Halted, fault_obs,
                             e.addr, e.instr, e.pc, e.pc4, e.valid, e.halted, e.fault);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        tick();
        push("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;

        push_fetch("fetch0", 32'h0, 32'h4); tick();
        push_fetch("fetch1", 32'h4, 32'h8); tick();

        Stall = 1'b1;
        push("stall1", 32'h8, 32'h2009_0002, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        push("stall2", 32'h8, 32'h2009_0002, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        Stall = 1'b0;
        push_fetch("stall release", 32'h8, 32'hC); tick();

        BranchTaken = 1'b1; BranchTarget = 32'h20; Stall = 1'b1; Flush = 1'b1;
        push("branch stall flush", 32'h20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        BranchTaken = 1'b0; Stall = 1'b0; Flush = 1'b0;
        push_fetch("target fetch", 32'h20, 32'h24); tick();

        BranchTaken = 1'b1; BranchTarget = 32'h22;
`ifdef IF_ALIGN_CHECK_EN
        push("misalign fault", 32'h24, imw(32'h24), 32'h24, 32'h28, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        BranchTarget = 32'h10;
        push("fault sticky", 32'h24, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
`else
        push_fetch("misalign ignored", 32'h24, 32'h20); tick();
        BranchTarget = 32'h10;
        push_fetch("aligned branch", 32'h20, 32'h10); tick();
`endif
        BranchTaken = 1'b0; rst = 1'b1;
        push("reset after redirect", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            push_fetch("sequential", 32'(4 * i), 32'(4 * i + 4));
            tick();
        end
        push_fetch("last word 124", 32'd124, 32'd128); tick();
        push("out of range bubble", 32'd128, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        push("halt hold", 32'd128, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        BranchTaken = 1'b1; BranchTarget = 32'h10;
        push("halt redirect", 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        BranchTaken = 1'b0;
        push_fetch("fetch after halt", 32'h10, 32'h14); tick();
        for (int k = 0; k < 11; k++) begin
            push_fetch("run to 0x40", 32'(32'h14 + 4 * k), 32'(32'h18 + 4 * k));
            tick();
        end

        rst = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h8; Stall = 1'b1;
        push("mid-run reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        rst = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
        push_fetch("first after reset", 32'h0, 32'h4); tick();

        BranchTaken = 1'b1; BranchTarget = 32'h7C; Stall = 1'b1;
        push("branch with stall", 32'h7C, imw(32'h0), 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        BranchTaken = 1'b0; Stall = 1'b0;
        push_fetch("fetch 0x7c", 32'h7C, 32'h80); tick();
        BranchTaken = 1'b1; BranchTarget = 32'h8;
        push("rescue out of range", 32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        BranchTaken = 1'b0;
        push_fetch("fetch 0x8", 32'h8, 32'hC); tick();

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        if (sbq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-clock MIPS-style CPU. Holds the program counter, drives the byte address into the 128-byte big-endian instruction memory (`IM`), captures the returned 32-bit word into the IF/ID pipeline register, and handles stall, flush, branch redirect and end-of-memory halt. Sits directly upstream of `IM` (address) and of the decode stage (IF/ID outputs).

## Interface

Parameters:
- `MEM_SIZE`, 128, instruction memory size in bytes; equals `INSTR_MEM_SIZE`.
- `RESET_PC`, 32'h0, PC value loaded on reset; word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Stall`  in  1  hold PC and IF/ID contents.
- `Flush`  in  1  replace IF/ID contents with a bubble.
- `BranchTaken`  in  1  redirect PC to `BranchTarget`.
- `BranchTarget`  in  32  redirect byte address.
- `InstrAddr`  out  32  byte address to `IM`; equals PC register.
- `Instr`  in  32  word returned combinationally by `IM`.
- `IfIdInstr`  out  32  registered instruction.
- `IfIdPC`  out  32  address of `IfIdInstr`.
- `IfIdPCPlus4`  out  32  `IfIdPC` + 4.
- `IfIdValid`  out  1  IF/ID holds a real instruction.
- `Halted`  out  1  fetch stopped (state HALT).
- `Fault`  out  1  misaligned redirect seen; present only with `IF_ALIGN_CHECK_EN`.

## Operation

- States: RUN, HALT.
- Reset: PC=`RESET_PC`, state RUN, `IfIdInstr`=32'h0 (NOP), `IfIdPC`=0, `IfIdPCPlus4`=0, `IfIdValid`=0, `Halted`=0, `Fault`=0.
- RUN, PC in range (PC+3 <= MEM_SIZE-1):
  - IF/ID: Flush → NOP, valid 0; else Stall → hold; else load `Instr`, PC, PC+4, valid 1.
  - PC: BranchTaken → `BranchTarget`; else Stall → hold; else PC+4.
- Priority: rst > Flush > Stall for IF/ID; rst > BranchTaken > Stall for PC. BranchTaken with Stall still redirects.
- RUN, PC out of range (PC+3 > MEM_SIZE-1): no fetch; IF/ID loads bubble (unless Stall); state → HALT next edge unless BranchTaken to an in-range target that same cycle.
- HALT: `Halted`=1, PC held, IF/ID loads bubble unless Stall. BranchTaken to in-range target → PC=target, state RUN. rst → RUN.
- Arithmetic: PC+4 is 32-bit unsigned, wraps modulo 2^32; a wrapped PC is out of range only if PC+3 > MEM_SIZE-1.

## Timing

- `InstrAddr` is the PC register output; changes only on `clk` edges.
- Fetch latency 1 cycle: word at `InstrAddr` in cycle n appears on `IfIdInstr` after edge n+1.
- Redirect penalty: the instruction fetched in the cycle `BranchTaken` is asserted enters IF/ID; the decode stage flushes it via `Flush` if required. Target reaches `InstrAddr` the next cycle.
- Out-of-range detection is combinational from PC; HALT is entered one edge later.
- Reset asserted mid-run overrides everything on that edge; first valid IF/ID occupant appears 1 cycle after `rst` deasserts.

## Configuration

- `IF_ALIGN_CHECK_EN` defined: BranchTaken with `BranchTarget[1:0]` != 0 sets sticky `Fault`=1, forces HALT, and PC is not updated; cleared only by rst.
- Not defined: `Fault` port absent; `BranchTarget[1:0]` ignored (PC loads {`BranchTarget[31:2]`, 2'b00}).

## Structure

- Shared package `if_pkg`: state enum (RUN, HALT), `NOP_INSTR`=32'h0, `PC_STEP`=4, `IF_MEM_SIZE`=128.
- One sub-module `if_id_reg`: IF/ID register with load/hold/bubble controls; PC, FSM and range check live in `instr_fetch`.

## Test plan

- Reset, IM preloaded words 0x20080001, 0x20090002 at 0, 4; run 3 cycles → `InstrAddr` 0,4,8; `IfIdInstr` 0x20080001 then 0x20090002, `IfIdPC` 0 then 4, `IfIdPCPlus4` 4 then 8.
- Stall held 2 cycles at PC=8 → `InstrAddr` stays 8, IF/ID unchanged, `IfIdValid` stays 1; release → PC 12.
- BranchTaken=1, `BranchTarget`=0x20, same cycle Stall=1 and Flush=1 → next cycle `InstrAddr`=0x20, `IfIdValid`=0, `IfIdInstr`=0.
- Sequential run to PC=124 → word at 124 captured; PC=128 → bubble, then `Halted`=1; BranchTaken to 0x10 in HALT → RUN, `InstrAddr`=0x10.
- With `IF_ALIGN_CHECK_EN`: BranchTarget=0x22 → `Fault`=1, `Halted`=1, PC unchanged; rst → `Fault`=0, PC=0. Without: PC=0x20.
- rst asserted while `IfIdValid`=1 at PC=0x40 → next edge PC=`RESET_PC`, `IfIdValid`=0, `IfIdInstr`=0, `Halted`=0.
